// File: rtl/cellrv32_icache_ctrl_pkg.sv
// Shared types and sizing helpers for the CELLRV32 instruction-cache controller.
package cellrv32_package;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CHECK   = 3'd1,
    S_DL_REQ  = 3'd2,
    S_DL_WAIT = 3'd3,
    S_RESYNC  = 3'd4,
    S_CLEAR   = 3'd5
  } icache_ctrl_state_t;

  // ceil(log2(n)); 0 for n <= 1
  function automatic int index_size_f(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // A single-word block still needs a 1-bit counter to keep the datapath legal.
  function automatic int icache_cnt_width_f(input int words);
    int r;
    r = index_size_f(words);
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/cellrv32_icache_ctrl.sv
// Instruction-cache sequencer: one-cycle hits, word-by-word block refill over the
// bus on a miss followed by a replay read, and whole-cache invalidation (fence.i).
module cellrv32_icache_ctrl
  import cellrv32_package::*;
#(
  parameter int ICACHE_BLOCK_SIZE = 16,
  parameter int ICACHE_NUM_BLOCKS = 4
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  input  logic               clear_i,
  input  logic [31:0]        host_addr_i,
  input  logic               host_re_i,
  output logic [31:0]        host_rdata_o,
  output logic               host_ack_o,
  output logic               host_err_o,
  output logic               cache_invalidate_o,
  output logic [31:0]        cache_host_addr_o,
  output logic               cache_host_re_o,
  input  logic [31:0]        cache_host_rdata_i,
  input  logic               cache_host_rstat_i,
  input  logic               cache_hit_i,
  output logic               cache_ctrl_en_o,
  output logic               cache_ctrl_we_o,
  output logic               cache_ctrl_wstat_o,
  output logic               cache_ctrl_tag_we_o,
  output logic               cache_ctrl_valid_o,
  output logic               cache_ctrl_invalid_o,
  output logic [31:0]        cache_ctrl_addr_o,
  output logic [31:0]        cache_ctrl_wdata_o,
  output logic [31:0]        bus_addr_o,
  output logic               bus_re_o,
  input  logic [31:0]        bus_rdata_i,
  input  logic               bus_ack_i,
  input  logic               bus_err_i,
  output icache_ctrl_state_t dbg_state_o
);

  localparam int W    = ICACHE_BLOCK_SIZE / 4;
  localparam int OFFS = index_size_f(ICACHE_BLOCK_SIZE);
  localparam int CW   = icache_cnt_width_f(W);
  localparam logic [CW-1:0] LAST_WORD = CW'(W - 1);

  if (ICACHE_BLOCK_SIZE < 4 || ICACHE_NUM_BLOCKS < 1) begin : g_param_check
    $error("cellrv32_icache_ctrl: invalid cache geometry");
  end

  // Handshake: host_re_i is a one-cycle request, answered by exactly one
  // single-cycle host_ack_o or host_err_o; bus_re_o is a one-cycle read pulse
  // answered later by a single-cycle bus_ack_i or bus_err_i.

  icache_ctrl_state_t state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               clr_q, clr_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        refill_addr;

  assign dbg_state_o = state_q;
  assign refill_addr = {addr_q[31:OFFS], {OFFS{1'b0}}} | (32'(cnt_q) << 2);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      clr_q   <= 1'b0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      clr_q   <= clr_d;
      addr_q  <= addr_d;
    end
  end

  always_comb begin
    state_d              = state_q;
    cnt_d                = cnt_q;
    clr_d                = clr_q | clear_i;
    addr_d               = addr_q;
    host_rdata_o         = '0;
    host_ack_o           = 1'b0;
    host_err_o           = 1'b0;
    cache_invalidate_o   = 1'b0;
    cache_host_addr_o    = '0;
    cache_host_re_o      = 1'b0;
    cache_ctrl_en_o      = 1'b0;
    cache_ctrl_we_o      = 1'b0;
    cache_ctrl_wstat_o   = 1'b0;
    cache_ctrl_tag_we_o  = 1'b0;
    cache_ctrl_valid_o   = 1'b0;
    cache_ctrl_invalid_o = 1'b0;
    cache_ctrl_addr_o    = '0;
    cache_ctrl_wdata_o   = '0;
    bus_addr_o           = '0;
    bus_re_o             = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // A pending (or same-cycle) clear wins; the colliding fetch is dropped.
        if (clr_q || clear_i) begin
          state_d = S_CLEAR;
        end else if (host_re_i) begin
          addr_d            = host_addr_i;
          cache_host_re_o   = 1'b1;
          cache_host_addr_o = host_addr_i;
          state_d           = S_CHECK;
        end
      end

      S_CHECK: begin
        if (cache_hit_i) begin
          host_rdata_o = cache_host_rdata_i;
          host_ack_o   = ~cache_host_rstat_i;
          host_err_o   = cache_host_rstat_i;
          state_d      = S_IDLE;
        end else begin
          // Drop the block's valid bit now so an aborted refill never leaves it usable.
          cnt_d                = '0;
          cache_ctrl_en_o      = 1'b1;
          cache_ctrl_invalid_o = 1'b1;
          cache_ctrl_addr_o    = refill_addr;
          state_d              = S_DL_REQ;
        end
      end

      S_DL_REQ: begin
        cache_ctrl_en_o   = 1'b1;
        cache_ctrl_addr_o = refill_addr;
        bus_re_o          = 1'b1;
        bus_addr_o        = refill_addr;
        state_d           = S_DL_WAIT;
      end

      S_DL_WAIT: begin
        cache_ctrl_en_o   = 1'b1;
        cache_ctrl_addr_o = refill_addr;
        if (bus_ack_i || bus_err_i) begin
          cache_ctrl_we_o    = 1'b1;
          cache_ctrl_wdata_o = bus_rdata_i;
          cache_ctrl_wstat_o = bus_err_i;
          if (cnt_q == LAST_WORD) begin
            cache_ctrl_tag_we_o = 1'b1;
            cache_ctrl_valid_o  = 1'b1;
            cnt_d               = '0;
            state_d             = S_RESYNC;
          end else begin
            cnt_d   = cnt_q + CW'(1);
            state_d = S_DL_REQ;
          end
        end
      end

      S_RESYNC: begin
        cache_host_re_o   = 1'b1;
        cache_host_addr_o = addr_q;
        state_d           = S_CHECK;
      end

      S_CLEAR: begin
        cache_invalidate_o = 1'b1;
        clr_d              = clear_i;
        state_d            = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: doc/cellrv32_icache_ctrl.md
# cellrv32_icache_ctrl

Sequencing controller for the CELLRV32 instruction cache. Accepts fetch requests from the CPU front end and answers hits from the cache memory in one cycle. On a miss it refills the whole block word-by-word over the processor bus through the cache memory's write-only control port, then replays the access. Also executes whole-cache invalidation (fence.i).

## Interface
- ICACHE_BLOCK_SIZE, 16: block size in bytes, power of 2, min 4; W = ICACHE_BLOCK_SIZE/4 words per block.
- ICACHE_NUM_BLOCKS, 4: forwarded to memory sizing; no effect on the FSM.
- clk_i  in  1  global clock, rising edge.
- rstn_i  in  1  asynchronous, active-low reset.
- clear_i  in  1  invalidate-whole-cache request (pulse).
- host_addr_i  in  32  fetch address, stable from request until ack/err.
- host_re_i  in  1  fetch request (single-cycle pulse).
- host_rdata_o  out  32  instruction word.
- host_ack_o  out  1  access done, data valid.
- host_err_o  out  1  access done, bus error on this word.
- cache_invalidate_o  out  1  to memory invalidate_i.
- cache_host_addr_o  out  32  / cache_host_re_o out 1: memory host port.
- cache_host_rdata_i  in  32  / cache_host_rstat_i in 1 / cache_hit_i in 1: memory read results, 1 cycle after read.
- cache_ctrl_en_o, cache_ctrl_we_o, cache_ctrl_wstat_o, cache_ctrl_tag_we_o, cache_ctrl_valid_o, cache_ctrl_invalid_o  out  1 each: memory control port.
- cache_ctrl_addr_o  out  32  / cache_ctrl_wdata_o out 32.
- bus_addr_o  out  32  word-aligned refill address.
- bus_re_o  out  1  read request (single-cycle pulse).
- bus_rdata_i  in  32  / bus_ack_i in 1 / bus_err_i in 1: bus response.

## Operation
- States: S_IDLE, S_CHECK, S_DL_REQ, S_DL_WAIT, S_RESYNC, S_CLEAR.
- Reset: state S_IDLE, word counter 0, clear-pending 0, latched address 0; every output 0.
- clear_i sets clear-pending in any state; pending is serviced only in S_IDLE and takes priority over a same-cycle host_re_i (that request is dropped; host re-issues after no ack).
- S_IDLE: pending clear -> S_CLEAR. Else host_re_i=1 -> latch host_addr_i, cache_host_re_o=1, cache_host_addr_o=host_addr_i -> S_CHECK.
- S_CHECK: cache_hit_i=1 -> host_rdata_o=cache_host_rdata_i, host_ack_o=~cache_host_rstat_i, host_err_o=cache_host_rstat_i -> S_IDLE. Miss -> counter=0, cache_ctrl_en_o=1, cache_ctrl_invalid_o=1 (selected block invalidated) -> S_DL_REQ.
- cache_ctrl_en_o held 1 from miss detection through last word write; cache_ctrl_addr_o = {latched[31:log2(BS)], counter, 2'b00}.
- S_DL_REQ: bus_re_o=1, bus_addr_o = cache_ctrl_addr_o -> S_DL_WAIT.
- S_DL_WAIT: wait indefinitely for bus_ack_i|bus_err_i. On response: cache_ctrl_we_o=1, wdata=bus_rdata_i, wstat=bus_err_i. If counter=W-1: also tag_we_o=1, valid_o=1 -> S_RESYNC; else counter+1 -> S_DL_REQ. An erroneous word is still stored; block marked valid.
- Counter width max(1, log2(W)); wraps to 0 after W-1.
- S_RESYNC: cache_ctrl_en_o=0, cache_host_re_o=1 with latched address -> S_CHECK (guaranteed hit).
- S_CLEAR: cache_invalidate_o=1 one cycle, pending cleared -> S_IDLE.
- host_re_i outside S_IDLE is ignored; ack/err are single-cycle, mutually exclusive.

## Timing
- Hit: request cycle 0 -> ack/err cycle 1.
- Miss, bus response one cycle after bus_re_o: ack at cycle 2W+3 (W=4 -> cycle 11); each bus wait cycle adds one.
- Clear: cache_invalidate_o cycle after clear_i if idle; else first cycle after return to S_IDLE.
- rstn_i low mid-refill: immediate S_IDLE, outputs 0; partially refilled block stays invalid (invalidated at miss).

## Structure
- State enum typedef and word-counter width function in cellrv32_package; reuse index_size_f.
- No sub-module; wrapper cellrv32_icache instantiates this controller with cellrv32_icache_memory.

## Test plan
- Cold fetch 0x0000_0100, W=4, zero-wait bus -> bus reads 0x100,0x104,0x108,0x10C, 4 ctrl writes, ack at cycle 11 with word at 0x100.
- Repeat fetch 0x0000_0104 -> ack cycle 1, no bus_re_o.
- Refill where word 2 (0x208) returns bus_err_i -> fetch 0x200 acks; later fetch 0x208 gives host_err_o cycle 1.
- clear_i during refill -> refill completes, ack, then cache_invalidate_o one cycle; next fetch same address misses.
- clear_i and host_re_i same idle cycle -> invalidate, no ack for that request.
- rstn_i low after second bus read -> all outputs 0; refetch misses and refills all W words.
